systolic_sequencer: RTL and testbench

Controller that sequences one matrix-multiply pass on the N x M systolic MAC array. It accepts a start request with inner dimension K and reads one column of A and one row of B per cycle from the operand buffers. It skews the operands onto the array's west and north edges, flushes the pipeline, pulses load to capture C, and reports done. It sits between the operand buffers and the array; its load output replaces the free-running per-PE control.

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/systolic_sequencer_if.sv | 30 +++
 rtl/systolic_sequencer_skew.sv | 39 +++
 rtl/systolic_sequencer.sv | 167 ++++++++++++++++
 tb/tb_systolic_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array sequencer.
package systolic_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int N_DEF          = 3;
  localparam int M_DEF          = 3;
  localparam int K_MAX_DEF      = 16;

  // Cycles needed for the last skewed operand to reach the far corner PE.
  function automatic int flush_len(input int n, input int m);
    return n + m - 1;
  endfunction

  localparam int FLUSH_CYC = flush_len(N_DEF, M_DEF);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    LOAD,
    DONE
  } state_t;

endpackage

// File: rtl/systolic_sequencer_if.sv
// Operand buffer read port: the sequencer issues reads, the buffers return one A column and one B row.
interface systolic_sequencer_if
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N          = N_DEF,
  parameter int M          = M_DEF,
  parameter int K_W        = $clog2(K_MAX_DEF + 1)
) ();

  logic                    rd_en;
  logic [K_W-1:0]          rd_addr;
  logic [N*DATA_WIDTH-1:0] a_rd_data;
  logic [M*DATA_WIDTH-1:0] b_rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  a_rd_data,
    input  b_rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output a_rd_data,
    output b_rd_data
  );

endinterface

// File: rtl/systolic_sequencer_skew.sv
// DEPTH-stage delay line for one operand lane; DEPTH=0 is a plain wire.
module skew_line
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = clk ^ rst ^ clr;
      assign dout = din;
    end else begin : g_regs
      logic [DATA_WIDTH-1:0] stage [DEPTH];

      // clr flushes the whole line in one cycle so an aborted pass leaves nothing in flight.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < DEPTH; d++) stage[d] <= '0;
        end else if (clr) begin
          for (int d = 0; d < DEPTH; d++) stage[d] <= '0;
        end else begin
          stage[0] <= din;
          for (int d = 1; d < DEPTH; d++) stage[d] <= stage[d-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences one matrix-multiply pass: clear, feed K skewed operand slices, flush, load C, done.
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N          = N_DEF,
  parameter int M          = M_DEF,
  parameter int K_MAX      = K_MAX_DEF,
  parameter int K_W        = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [K_W-1:0]          k_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [N*DATA_WIDTH-1:0] a_feed,
  output logic [M*DATA_WIDTH-1:0] b_feed,
  output logic                    mac_clr,
  output logic                    load,
  systolic_sequencer_if.master    buf_if
);

  localparam int FLUSH_LEN = flush_len(N, M);
  localparam int FC_W      = $clog2(FLUSH_LEN + 1);
  localparam logic [FC_W-1:0] F_LAST = FC_W'(FLUSH_LEN - 1);

  state_t          state, state_n;
  logic [K_W-1:0]  k_cnt, k_n;
  logic [FC_W-1:0] f_cnt, f_n;
  logic [K_W-1:0]  k_len_q;
  logic            err_q, err_n;
  logic            accept;
  logic            rd_en_int;
  logic            rd_valid;
  logic            skew_clr;
  logic            k_legal;

  logic [N*DATA_WIDTH-1:0] a_cap;
  logic [M*DATA_WIDTH-1:0] b_cap;

  assign k_legal = (k_len != '0) && (k_len <= K_W'(K_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      k_cnt    <= '0;
      f_cnt    <= '0;
      k_len_q  <= '0;
      err_q    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      k_cnt    <= k_n;
      f_cnt    <= f_n;
      err_q    <= err_n;
      rd_valid <= rd_en_int;
      if (accept) k_len_q <= k_len;
    end
  end

  always_comb begin
    state_n   = state;
    k_n       = k_cnt;
    f_n       = f_cnt;
    err_n     = 1'b0;
    accept    = 1'b0;
    busy      = (state != IDLE);
    mac_clr   = 1'b0;
    rd_en_int = 1'b0;
    load      = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (k_legal) begin
            accept  = 1'b1;
            state_n = CLEAR;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      CLEAR: begin
        mac_clr = 1'b1;
        k_n     = '0;
        state_n = FEED;
      end
      FEED: begin
        rd_en_int = 1'b1;
        if (k_cnt == k_len_q - 1'b1) begin
          k_n     = '0;
          f_n     = '0;
          state_n = FLUSH;
        end else begin
          k_n = k_cnt + 1'b1;
        end
      end
      FLUSH: begin
        if (f_cnt == F_LAST) begin
          f_n     = '0;
          state_n = LOAD;
        end else begin
          f_n = f_cnt + 1'b1;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Abort wins over every transition and also squashes this cycle's read, load and done.
    if (abort && state != IDLE) begin
      state_n   = IDLE;
      k_n       = '0;
      f_n       = '0;
      rd_en_int = 1'b0;
      load      = 1'b0;
      done      = 1'b0;
    end
  end

  assign err            = err_q;
  assign skew_clr       = abort && busy;
  assign buf_if.rd_en   = rd_en_int;
  assign buf_if.rd_addr = (state == FEED) ? k_cnt : '0;

  // Buffer data is only trusted in the cycle after a read; otherwise idle PEs see zeros.
  assign a_cap = rd_valid ? buf_if.a_rd_data : '0;
  assign b_cap = rd_valid ? buf_if.b_rd_data : '0;

  for (genvar g = 0; g < N + M; g++) begin : g_lane
    if (g < N) begin : g_a
      skew_line #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (g)
      ) u_skew (
        .clk (clk),
        .rst (rst),
        .clr (skew_clr),
        .din (a_cap[g*DATA_WIDTH +: DATA_WIDTH]),
        .dout(a_feed[g*DATA_WIDTH +: DATA_WIDTH])
      );
    end else begin : g_b
      skew_line #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (g - N)
      ) u_skew (
        .clk (clk),
        .rst (rst),
        .clr (skew_clr),
        .din (b_cap[(g-N)*DATA_WIDTH +: DATA_WIDTH]),
        .dout(b_feed[(g-N)*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed-plus-random bench: a pass timeline model predicts every output cycle by cycle.
module tb_systolic_sequencer;
  import systolic_pkg::*;

  localparam int DW = 32;
  localparam int NL = 3;
  localparam int ML = 3;
  localparam int KM = 16;
  localparam int KW = $clog2(KM + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic busy, done, err, mac_clr, load;
  logic [NL*DW-1:0] a_feed;
  logic [ML*DW-1:0] b_feed;

  systolic_sequencer_if #(.DATA_WIDTH(DW), .N(NL), .M(ML), .K_W(KW)) bus ();

  systolic_sequencer #(
    .DATA_WIDTH(DW), .N(NL), .M(ML), .K_MAX(KM), .K_W(KW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .k_len  (k_len),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .a_feed (a_feed),
    .b_feed (b_feed),
    .mac_clr(mac_clr),
    .load   (load),
    .buf_if (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] a_mem [KM][NL];
  logic [DW-1:0] b_mem [KM][ML];
  logic          req_q = 1'b0;
  logic [KW-1:0] addr_q = '0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Buffer model: returns the addressed slice one cycle after a read, garbage otherwise.
  task automatic drive_buffer();
    for (int i = 0; i < NL; i++)
      bus.a_rd_data[i*DW +: DW] = (req_q && addr_q < KW'(KM)) ? a_mem[addr_q][i] : $urandom;
    for (int j = 0; j < ML; j++)
      bus.b_rd_data[j*DW +: DW] = (req_q && addr_q < KW'(KM)) ? b_mem[addr_q][j] : $urandom;
  endtask

  task automatic tick(input logic st, input logic ab, input logic [KW-1:0] kl);
    @(posedge clk);
    #1;
    start = st;
    abort = ab;
    k_len = kl;
    drive_buffer();
    @(negedge clk);
    req_q  = bus.rd_en;
    addr_q = bus.rd_addr;
  endtask

  // Slice kk of lane i reaches the array edge i cycles after it arrives from the buffer.
  function automatic logic [NL*DW-1:0] exp_a(input int c, input int k);
    logic [NL*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++) begin
      int kk;
      kk = c - 3 - i;
      if (kk >= 0 && kk < k) v[i*DW +: DW] = a_mem[kk][i];
    end
    return v;
  endfunction

  function automatic logic [ML*DW-1:0] exp_b(input int c, input int k);
    logic [ML*DW-1:0] v;
    v = '0;
    for (int j = 0; j < ML; j++) begin
      int kk;
      kk = c - 3 - j;
      if (kk >= 0 && kk < k) v[j*DW +: DW] = b_mem[kk][j];
    end
    return v;
  endfunction

  task automatic check_cycle(input int c, input int k, input bit dead, input bit ab);
    int  lc;
    bit  live, feeding;
    lc      = k + NL + ML + 1;
    live    = !dead;
    feeding = live && c >= 2 && c <= k + 1;
    check($sformatf("busy c%0d", c), busy, live && c <= lc + 1);
    check($sformatf("mac_clr c%0d", c), mac_clr, live && c == 1);
    if (!ab) check($sformatf("rd_en c%0d", c), bus.rd_en, feeding);
    check($sformatf("rd_addr c%0d", c), bus.rd_addr, feeding ? c - 2 : 0);
    check($sformatf("load c%0d", c), load, live && !ab && c == lc);
    check($sformatf("done c%0d", c), done, live && !ab && c == lc + 1);
    check($sformatf("err c%0d", c), err, 1'b0);
    check($sformatf("a_feed c%0d", c), a_feed, live ? exp_a(c, k) : '0);
    check($sformatf("b_feed c%0d", c), b_feed, live ? exp_b(c, k) : '0);
  endtask

  // Cycle 0 presents start; cycles 1..stop follow the pass timeline (stop=0 runs through DONE).
  task automatic run_pass(input int k, input bit hold, input int abort_at, input int stop_at,
                          input bit ab_idle);
    int  last;
    bit  ab;
    last = (stop_at > 0) ? stop_at : k + NL + ML + 2;
    for (int kk = 0; kk < KM; kk++) begin
      for (int i = 0; i < NL; i++) a_mem[kk][i] = $urandom;
      for (int j = 0; j < ML; j++) b_mem[kk][j] = $urandom;
    end
    tick(1'b1, ab_idle, KW'(k));
    check("busy c0", busy, 1'b0);
    check("err c0", err, 1'b0);
    for (int c = 1; c <= last; c++) begin
      ab = (c == abort_at);
      tick(hold, ab, KW'($urandom_range(0, 31)));
      check_cycle(c, k, abort_at > 0 && c > abort_at, ab);
    end
  endtask

  task automatic reject(input int kv);
    tick(1'b1, 1'b0, KW'(kv));
    check($sformatf("err same cycle k=%0d", kv), err, 1'b0);
    tick(1'b0, 1'b0, '0);
    check($sformatf("err pulse k=%0d", kv), err, 1'b1);
    check($sformatf("busy reject k=%0d", kv), busy, 1'b0);
    check($sformatf("rd_en reject k=%0d", kv), bus.rd_en, 1'b0);
    tick(1'b0, 1'b0, '0);
    check($sformatf("err clears k=%0d", kv), err, 1'b0);
    check($sformatf("mac_clr reject k=%0d", kv), mac_clr, 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, done, 1'b0);
    check({tag, " err"}, err, 1'b0);
    check({tag, " load"}, load, 1'b0);
    check({tag, " mac_clr"}, mac_clr, 1'b0);
    check({tag, " rd_en"}, bus.rd_en, 1'b0);
    check({tag, " rd_addr"}, bus.rd_addr, '0);
    check({tag, " a_feed"}, a_feed, '0);
    check({tag, " b_feed"}, b_feed, '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.a_rd_data = {NL{32'hDEAD_BEEF}};
    bus.b_rd_data = {ML{32'hCAFE_F00D}};
    #2;
    check_quiet("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    run_pass(4, 1'b0, 0, 0, 1'b0);
    reject(0);
    reject(17);
    reject(31);
    run_pass(4, 1'b0, 4, 0, 1'b0);
    run_pass(1, 1'b0, 0, 0, 1'b0);
    run_pass(2, 1'b0, 2 + NL + ML + 1, 0, 1'b0);
    run_pass(3, 1'b0, 0, 0, 1'b1);
    run_pass(2, 1'b1, 0, 0, 1'b0);
    run_pass(2, 1'b0, 0, 0, 1'b0);

    run_pass(3, 1'b0, 0, 6, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_quiet("async reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    req_q = 1'b0;
    tick(1'b0, 1'b0, '0);
    check_quiet("after reset");
    run_pass(KM, 1'b0, 0, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      int kr;
      kr = $urandom_range(1, KM);
      run_pass(kr, 1'b0, (r == 3) ? $urandom_range(1, kr + NL + ML + 2) : 0, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
